// File: rtl/reg_file_operand_fetch_if.sv
// Operand-fetch bus: decode-side read request, ALU-stage hazard info and
// writeback from the ALU, plus the latched operands and hazard status going back out.
interface reg_file_operand_fetch_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              id_valid;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              use_a;
    logic              use_b;
    logic              ex_wr;
    logic [ADDR_W-1:0] ex_addr;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_h_en;
    logic              wb_l_en;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              hazard;
    logic [CNT_W-1:0]  hazard_cnt;

    modport master (
        output stall, id_valid, rd_addr_a, rd_addr_b, use_a, use_b,
               ex_wr, ex_addr, wb_en, wb_addr, wb_h_en, wb_l_en, wb_data,
        input  in_a, in_b, hazard, hazard_cnt
    );

    modport slave (
        input  stall, id_valid, rd_addr_a, rd_addr_b, use_a, use_b,
               ex_wr, ex_addr, wb_en, wb_addr, wb_h_en, wb_l_en, wb_data,
        output in_a, in_b, hazard, hazard_cnt
    );
endinterface

// File: rtl/reg_file_operand_fetch.sv
// Operand-fetch stage: byte-enabled register file with write-to-read bypass,
// registered ALU operands and a combinational RAW hazard detect with a saturating counter.
module reg_file_operand_fetch #(
    parameter int          NUM_REGS  = 16,
    parameter logic [15:0] RESET_VAL = 16'h0000,
    parameter int          CNT_W     = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    reg_file_operand_fetch_if.slave bus
);
    logic [15:0]      r_regs [NUM_REGS];
    logic [15:0]      r_in_a;
    logic [15:0]      r_in_b;
    logic [CNT_W-1:0] r_hazard_cnt;

    logic        w_wr_hi;
    logic        w_wr_lo;
    logic [15:0] w_byp_a;
    logic [15:0] w_byp_b;
    logic        w_hazard;
    logic        w_fetch;

    // Both byte enables low is the ALU swap result, which writes the whole word.
    assign w_wr_hi = bus.wb_h_en | (~bus.wb_h_en & ~bus.wb_l_en);
    assign w_wr_lo = bus.wb_l_en | (~bus.wb_h_en & ~bus.wb_l_en);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_byp_a = r_regs[bus.rd_addr_a];
        w_byp_b = r_regs[bus.rd_addr_b];
        if (bus.wb_en && bus.wb_addr == bus.rd_addr_a) begin
            if (w_wr_hi) w_byp_a[15:8] = bus.wb_data[15:8];
            if (w_wr_lo) w_byp_a[7:0]  = bus.wb_data[7:0];
        end
        if (bus.wb_en && bus.wb_addr == bus.rd_addr_b) begin
            if (w_wr_hi) w_byp_b[15:8] = bus.wb_data[15:8];
            if (w_wr_lo) w_byp_b[7:0]  = bus.wb_data[7:0];
        end
    end

    assign w_hazard = bus.id_valid & bus.ex_wr &
                      ((bus.use_a & (bus.rd_addr_a == bus.ex_addr)) |
                       (bus.use_b & (bus.rd_addr_b == bus.ex_addr)));

    assign w_fetch = ~bus.stall & ~w_hazard & bus.id_valid;

    // NOTE: the array itself is reset because every register must read RESET_VAL
    // after reset; this rules out a RAM macro and keeps it as flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
        end else if (bus.wb_en) begin
            // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
            if (w_wr_hi) r_regs[bus.wb_addr][15:8] <= bus.wb_data[15:8];
            if (w_wr_lo) r_regs[bus.wb_addr][7:0]  <= bus.wb_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_a <= RESET_VAL;
            r_in_b <= RESET_VAL;
        end else if (w_fetch) begin
            r_in_a <= w_byp_a;
            r_in_b <= w_byp_b;
        end
    end

    // Counts hazard cycles regardless of stall; sticks at all-ones until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hazard_cnt <= '0;
        end else if (w_hazard && r_hazard_cnt != '1) begin
            r_hazard_cnt <= r_hazard_cnt + 1'b1;
        end
    end

    assign bus.in_a       = r_in_a;
    assign bus.in_b       = r_in_b;
    assign bus.hazard     = w_hazard;
    assign bus.hazard_cnt = r_hazard_cnt;
endmodule

// File: tb/tb_reg_file_operand_fetch.sv
// Self-checking bench for reg_file_operand_fetch: table-driven fetch/writeback vectors
// with an operand scoreboard, plus hand sequences for hazard, stall, saturation and reset.
module tb_reg_file_operand_fetch;
    logic clk;
    logic rst_n;

    reg_file_operand_fetch_if #(.ADDR_W(4), .DATA_W(16), .CNT_W(16)) bus ();

    reg_file_operand_fetch #(
        .NUM_REGS (16),
        .RESET_VAL(16'h0000),
        .CNT_W    (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id_valid;
        logic        stall;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        ua;
        logic        ub;
        logic        ex_wr;
        logic [3:0]  ex_addr;
        logic        wb_en;
        logic [3:0]  wb_addr;
        logic        h_en;
        logic        l_en;
        logic [15:0] wb_data;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_haz;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic st,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic ua, input logic ub,
                                input logic exw, input logic [3:0] exa,
                                input logic wbe, input logic [3:0] wba,
                                input logic h, input logic l, input logic [15:0] d,
                                input logic [15:0] ea, input logic [15:0] eb,
                                input logic eh);
        vec_t v;
        v.id_valid = iv;  v.stall = st;   v.ra = ra;      v.rb = rb;
        v.ua = ua;        v.ub = ub;      v.ex_wr = exw;  v.ex_addr = exa;
        v.wb_en = wbe;    v.wb_addr = wba; v.h_en = h;    v.l_en = l;
        v.wb_data = d;    v.exp_a = ea;   v.exp_b = eb;   v.exp_haz = eh;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.id_valid  = v.id_valid;
        bus.stall     = v.stall;
        bus.rd_addr_a = v.ra;
        bus.rd_addr_b = v.rb;
        bus.use_a     = v.ua;
        bus.use_b     = v.ub;
        bus.ex_wr     = v.ex_wr;
        bus.ex_addr   = v.ex_addr;
        bus.wb_en     = v.wb_en;
        bus.wb_addr   = v.wb_addr;
        bus.wb_h_en   = v.h_en;
        bus.wb_l_en   = v.l_en;
        bus.wb_data   = v.wb_data;
    endtask

    // Called just after a rising edge: drive, check hazard, push expectation,
    // cross the next edge, then pop and compare the latched operands.
    task automatic run_cycle(input string name, input vec_t v);
        exp_t e;
        exp_t got;
        drive(v);
        #1;
        check({name, ".hazard"}, {31'd0, bus.hazard}, {31'd0, v.exp_haz});
        e.a = v.exp_a;
        e.b = v.exp_b;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check({name, ".in_a"}, {16'd0, bus.in_a}, {16'd0, got.a});
        check({name, ".in_b"}, {16'd0, bus.in_b}, {16'd0, got.b});
    endtask

    vec_t tbl [11];
    vec_t v;

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        tbl[0]  = mk(1,0, 4'd3,4'd0, 1,1, 0,4'd0, 1,4'd3, 1,1,16'hA55A, 16'hA55A,16'h0000, 0);
        tbl[1]  = mk(1,0, 4'd5,4'd3, 1,1, 0,4'd0, 1,4'd5, 1,1,16'h1234, 16'h1234,16'hA55A, 0);
        tbl[2]  = mk(1,0, 4'd5,4'd5, 1,1, 0,4'd0, 1,4'd5, 1,0,16'hBEEF, 16'hBE34,16'hBE34, 0);
        tbl[3]  = mk(1,0, 4'd5,4'd1, 1,1, 0,4'd0, 1,4'd5, 0,1,16'h00CC, 16'hBECC,16'h0000, 0);
        tbl[4]  = mk(1,0, 4'd3,4'd5, 1,1, 0,4'd0, 1,4'd5, 0,0,16'h7788, 16'hA55A,16'h7788, 0);
        tbl[5]  = mk(1,0, 4'd5,4'd5, 1,1, 0,4'd0, 0,4'd0, 0,0,16'h0000, 16'h7788,16'h7788, 0);
        tbl[6]  = mk(1,0, 4'd9,4'd9, 1,1, 0,4'd0, 1,4'd9, 1,0,16'hFFFF, 16'hFF00,16'hFF00, 0);
        tbl[7]  = mk(1,0, 4'd9,4'd2, 1,1, 0,4'd0, 0,4'd0, 0,0,16'h0000, 16'hFF00,16'h0000, 0);
        tbl[8]  = mk(1,0, 4'd3,4'd5, 0,1, 1,4'd3, 0,4'd0, 0,0,16'h0000, 16'hA55A,16'h7788, 0);
        tbl[9]  = mk(1,0, 4'd3,4'd9, 1,1, 0,4'd0, 0,4'd3, 1,1,16'h1111, 16'hA55A,16'hFF00, 0);
        tbl[10] = mk(1,0, 4'd3,4'd3, 1,1, 0,4'd0, 0,4'd0, 0,0,16'h0000, 16'hA55A,16'hA55A, 0);

        // Reset state
        rst_n = 1'b0;
        drive(mk(0,0, 4'd0,4'd0, 0,0, 0,4'd0, 0,4'd0, 0,0,16'h0000, 16'h0,16'h0, 0));
        #1;
        check("reset.in_a", {16'd0, bus.in_a}, 32'h0);
        check("reset.in_b", {16'd0, bus.in_b}, 32'h0);
        check("reset.hazard", {31'd0, bus.hazard}, 32'h0);
        check("reset.cnt", {16'd0, bus.hazard_cnt}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Read every register after reset
        for (int i = 0; i < 16; i++) begin
            run_cycle($sformatf("rd_r%0d", i),
                      mk(1,0, i[3:0], 4'(15 - i), 1,1, 0,4'd0, 0,4'd0, 0,0,16'h0000,
                         16'h0000,16'h0000, 0));
        end
        check("rd_all.cnt", {16'd0, bus.hazard_cnt}, 32'h0);

        // Bypass, byte masks, wb_en gating
        for (int i = 0; i < 11; i++) run_cycle($sformatf("tbl%0d", i), tbl[i]);

        // Sustained hazard on B: latch holds, counter counts
        for (int i = 0; i < 3; i++) begin
            run_cycle($sformatf("haz%0d", i),
                      mk(1,0, 4'd0,4'd7, 0,1, 1,4'd7, 0,4'd0, 0,0,16'h0000,
                         16'hA55A,16'hA55A, 1));
        end
        check("haz.cnt3", {16'd0, bus.hazard_cnt}, 32'd3);
        run_cycle("haz_clear", mk(1,0, 4'd0,4'd7, 0,1, 0,4'd7, 0,4'd0, 0,0,16'h0000,
                                  16'h0000,16'h0000, 0));
        check("haz_clear.cnt", {16'd0, bus.hazard_cnt}, 32'd3);

        // Stall holds operands while a writeback still lands in the array
        run_cycle("stall_wb", mk(1,1, 4'd3,4'd5, 1,1, 0,4'd0, 1,4'd7, 1,1,16'h5A5A,
                                 16'h0000,16'h0000, 0));
        run_cycle("stall_haz", mk(1,1, 4'd3,4'd5, 1,1, 1,4'd3, 0,4'd0, 0,0,16'h0000,
                                  16'h0000,16'h0000, 1));
        check("stall_haz.cnt", {16'd0, bus.hazard_cnt}, 32'd4);
        run_cycle("post_stall", mk(1,0, 4'd7,4'd7, 1,1, 0,4'd0, 0,4'd0, 0,0,16'h0000,
                                   16'h5A5A,16'h5A5A, 0));

        // Saturation: 4 + 65541 hazard cycles exceeds 16'hFFFF
        drive(mk(1,0, 4'd0,4'd0, 1,0, 1,4'd0, 0,4'd0, 0,0,16'h0000, 16'h0,16'h0, 1));
        repeat (65541) @(posedge clk);
        #1;
        check("sat.cnt", {16'd0, bus.hazard_cnt}, 32'h0000FFFF);
        @(posedge clk);
        #1;
        check("sat.hold", {16'd0, bus.hazard_cnt}, 32'h0000FFFF);
        check("sat.in_a", {16'd0, bus.in_a}, 32'h00005A5A);

        // Asynchronous reset mid-hazard, sampled before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.cnt", {16'd0, bus.hazard_cnt}, 32'h0);
        check("arst.in_a", {16'd0, bus.in_a}, 32'h0);
        check("arst.in_b", {16'd0, bus.in_b}, 32'h0);
        drive(mk(0,0, 4'd0,4'd0, 0,0, 0,4'd0, 0,4'd0, 0,0,16'h0000, 16'h0,16'h0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst.idle_a", {16'd0, bus.in_a}, 32'h0);
        run_cycle("post_rst.rd", mk(1,0, 4'd3,4'd7, 1,1, 0,4'd0, 0,4'd0, 0,0,16'h0000,
                                    16'h0000,16'h0000, 0));
        check("post_rst.cnt", {16'd0, bus.hazard_cnt}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_operand_fetch.md
Name: reg_file_operand_fetch

Overview:
- Operand-fetch stage directly upstream of the ALU: 16 x 16-bit register file, byte-enabled writeback, write-to-read bypass.
- Registered operand latch that drives the ALU in_a/in_b.
- Combinational read-after-write hazard detect that drives the ALU data_hazard input and stalls fetch/decode.
- Writeback data comes from ALU alu_out, with the matching h_en/l_en of the instruction that produced it.

Parameters:
NUM_REGS, 16, register count; address width is clog2(NUM_REGS), 4 at default
RESET_VAL, 16'h0000, value loaded into every register and operand latch on reset
CNT_W, 16, width of saturating hazard-stall counter

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  external hold (e.g. memory wait); freezes operand latch
id_valid  in  1  instruction in decode is valid
rd_addr_a  in  4  source register A
rd_addr_b  in  4  source register B
use_a  in  1  instruction reads A
use_b  in  1  instruction reads B
ex_wr  in  1  instruction currently in ALU stage will write a register
ex_addr  in  4  destination of instruction in ALU stage
wb_en  in  1  writeback valid this cycle
wb_addr  in  4  writeback destination
wb_h_en  in  1  writeback high-byte enable (ALU h_en)
wb_l_en  in  1  writeback low-byte enable (ALU l_en)
wb_data  in  16  writeback data (ALU alu_out)
in_a  out  16  registered operand A to ALU
in_b  out  16  registered operand B to ALU
hazard  out  1  RAW hazard; drives ALU data_hazard and upstream stall
hazard_cnt  out  CNT_W  saturating count of hazard cycles

Behaviour:
- Reset (rst_n=0, async): all registers, in_a, in_b = RESET_VAL; hazard_cnt = 0. hazard is combinational; it reads 0 only when its inputs are idle.
- Byte-write masks:
  - wr_hi = wb_h_en | (~wb_h_en & ~wb_l_en); wr_lo = wb_l_en | (~wb_h_en & ~wb_l_en).
  - Both enables low is the ALU swap case and writes the full word.
  - wb_en gates every write.
- Write: on posedge with wb_en=1, reg[wb_addr][15:8] <= wb_data[15:8] if wr_hi, and reg[wb_addr][7:0] <= wb_data[7:0] if wr_lo.
- Writes are never blocked by stall or hazard. All registers are writable; none is hardwired.
- Read bypass (combinational): if wb_en and wb_addr == rd_addr_x, each byte comes from wb_data when its mask bit is set, otherwise from the array. The read returns the post-write value in the same cycle.
- Hazard: hazard = id_valid & ex_wr & ((use_a & rd_addr_a==ex_addr) | (use_b & rd_addr_b==ex_addr)). Pure combinational, zero latency.
- Operand latch: on posedge, when ~stall & ~hazard & id_valid, in_a <= bypassed A and in_b <= bypassed B. Otherwise both hold.
- Unused operands (use_x=0) are still latched from rd_addr_x, which keeps the logic simple.
- Latency: register write to in_a visible = 1 cycle via bypass when the read coincides with the writeback, otherwise 2 cycles.
- Hazard counter: on posedge, when hazard=1 and hazard_cnt != all-ones, increment. It saturates at 2^CNT_W-1 and is cleared only by reset.
- Simultaneous hazard and stall: latch holds; counter still counts hazard.
- Same register on A and B: both ports return an identical bypassed value.
- Reset asserted mid-stall or mid-hazard: state clears immediately. After release, in_a/in_b show RESET_VAL until the first valid unstalled fetch.

Test Plan:
1. Reset, then read r0..r15 with id_valid=1, no writes -> in_a=in_b=16'h0000 one cycle after each fetch; hazard_cnt=0.
2. wb_en=1, wb_addr=3, wb_data=16'hA55A, h_en=l_en=1, same cycle rd_addr_a=3 -> in_a=16'hA55A next edge (bypass).
3. With r5=16'h1234, write r5 with wb_data=16'hBEEF, h_en=1, l_en=0 -> r5=16'hBE34. Then l_en only with 16'h00CC -> 16'hBECC. Then both enables 0 with 16'h7788 -> 16'h7788.
4. ex_wr=1, ex_addr=7, rd_addr_b=7, use_b=1, id_valid=1 for 3 cycles -> hazard=1 each cycle, in_b unchanged, hazard_cnt=3. Then ex_wr=0 -> hazard=0 and in_b latches.
5. use_a=0 with rd_addr_a==ex_addr, ex_wr=1 -> hazard=0. stall=1 with new addresses -> in_a/in_b hold; a writeback during stall still updates the array.
6. Force hazard continuously for 2^16+5 cycles -> hazard_cnt=16'hFFFF. Pulse rst_n low mid-run -> hazard_cnt, in_a, in_b = 0 asynchronously, before the next edge.
